// File: rtl/vga_timing_pkg.sv
// Shared phase encoding, default 640x480@60 timing and boundary helpers
// for the VGA timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CW       = 16;

    function automatic int total_len(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

    function automatic int active_end(input int a);
        return a - 1;
    endfunction

    function automatic int front_end(input int a, input int f);
        return a + f - 1;
    endfunction

    function automatic int sync_start(input int a, input int f);
        return a + f;
    endfunction

    function automatic int sync_end(input int a, input int f, input int s);
        return a + f + s - 1;
    endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// Wrapping counter with a four-phase FSM (active/front/sync/back); used once
// per axis. Exposes both the registered and the next count/phase.
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int CW     = DEF_CW,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output phase_t        phase,
    output phase_t        phase_nxt,
    output logic          wrap
);

    localparam int LAST_I      = total_len(ACTIVE, FRONT, SYNC, BACK) - 1;
    localparam int ACT_END_I   = active_end(ACTIVE);
    localparam int FRONT_END_I = front_end(ACTIVE, FRONT);
    localparam int SYNC_END_I  = sync_end(ACTIVE, FRONT, SYNC);

    localparam logic [CW-1:0] LAST      = LAST_I[CW-1:0];
    localparam logic [CW-1:0] ACT_END   = ACT_END_I[CW-1:0];
    localparam logic [CW-1:0] FRONT_END = FRONT_END_I[CW-1:0];
    localparam logic [CW-1:0] SYNC_END  = SYNC_END_I[CW-1:0];

    logic [CW-1:0] r_count;
    phase_t        r_phase;
    logic [CW-1:0] w_count_nxt;
    phase_t        w_phase_nxt;
    logic          w_wrap;

    // NOTE: state uses non-blocking assignments; the next values hold when step=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // NOTE: defaults first so every path assigns and no latch is inferred.
    always_comb begin
        w_wrap      = step && (r_count == LAST);
        w_count_nxt = r_count;
        w_phase_nxt = r_phase;
        if (step) begin
            w_count_nxt = w_wrap ? '0 : r_count + CW'(1);
            unique case (r_phase)
                PH_ACTIVE: if (r_count == ACT_END)   w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (r_count == FRONT_END) w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_count == SYNC_END)  w_phase_nxt = PH_BACK;
                PH_BACK:   if (r_count == LAST)      w_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        count     = r_count;
        count_nxt = w_count_nxt;
        phase     = r_phase;
        phase_nxt = w_phase_nxt;
        wrap      = w_wrap;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing top: horizontal/vertical phase counters plus registered sync,
// video_on, coordinate and strobe outputs aligned with the counters.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          line_start,
    output logic          frame_start
);

    logic [CW-1:0] w_hcnt, w_hcnt_nxt, w_vcnt, w_vcnt_nxt;
    phase_t        w_hph, w_hph_nxt, w_vph, w_vph_nxt;
    logic          w_h_wrap, w_v_wrap, w_vo_nxt;

    logic          r_running, r_hsync, r_vsync, r_video_on;
    logic          r_line_start, r_frame_start;
    logic [CW-1:0] r_px, r_py;

    vga_phase_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_hcnt (
        .clk(clk), .rst(rst), .step(pix_en),
        .count(w_hcnt), .count_nxt(w_hcnt_nxt),
        .phase(w_hph), .phase_nxt(w_hph_nxt), .wrap(w_h_wrap)
    );

    vga_phase_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_vcnt (
        .clk(clk), .rst(rst), .step(w_h_wrap & pix_en),
        .count(w_vcnt), .count_nxt(w_vcnt_nxt),
        .phase(w_vph), .phase_nxt(w_vph_nxt), .wrap(w_v_wrap)
    );

    // Decoding from the next counter state keeps the registered outputs in
    // step with hcnt/vcnt; the first pix_en already counts as running.
    always_comb begin
        w_vo_nxt = (r_running | pix_en) && (w_hph_nxt == PH_ACTIVE) && (w_vph_nxt == PH_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running     <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_px          <= '0;
            r_py          <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
            if (pix_en) begin
                r_running  <= 1'b1;
                r_hsync    <= (w_hph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_vsync    <= (w_vph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_video_on <= w_vo_nxt;
                r_px       <= w_vo_nxt ? w_hcnt_nxt : '0;
                r_py       <= w_vo_nxt ? w_vcnt_nxt : '0;
            end
        end
    end

    always_comb begin
        hcnt        = w_hcnt;
        vcnt        = w_vcnt;
        hsync       = r_hsync;
        vsync       = r_vsync;
        video_on    = r_video_on;
        px          = r_px;
        py          = r_py;
        line_start  = r_line_start;
        frame_start = r_frame_start;
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default 640x480 timing over the first line, and a tiny
// active-high timing over a full frame with sparse pix_en and a mid-frame reset.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, en_d, rst_s, en_s;

    logic [15:0] d_hcnt, d_vcnt, d_px, d_py;
    logic        d_hsync, d_vsync, d_vo, d_ln, d_fr;
    logic [15:0] s_hcnt, s_vcnt, s_px, s_py;
    logic        s_hsync, s_vsync, s_vo, s_ln, s_fr;

    vga_timing_ctrl dut_d (
        .clk(clk), .rst(rst_d), .pix_en(en_d),
        .hcnt(d_hcnt), .vcnt(d_vcnt), .hsync(d_hsync), .vsync(d_vsync),
        .video_on(d_vo), .px(d_px), .py(d_py),
        .line_start(d_ln), .frame_start(d_fr)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1), .CW(16)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(en_s),
        .hcnt(s_hcnt), .vcnt(s_vcnt), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_vo), .px(s_px), .py(s_py),
        .line_start(s_ln), .frame_start(s_fr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected outputs of the 640x480 instance at position (h,v).
    task automatic exp_d(input string tag, input int h, input int v,
                         input bit run, input bit ln, input bit fr);
        bit vo;
        vo = run && (h < 640) && (v < 480);
        check({tag, ".hcnt"},  int'(d_hcnt),  h);
        check({tag, ".vcnt"},  int'(d_vcnt),  v);
        check({tag, ".hsync"}, int'(d_hsync), (h >= 656 && h <= 751) ? 0 : 1);
        check({tag, ".vsync"}, int'(d_vsync), (v >= 490 && v <= 491) ? 0 : 1);
        check({tag, ".von"},   int'(d_vo),    int'(vo));
        check({tag, ".px"},    int'(d_px),    vo ? h : 0);
        check({tag, ".py"},    int'(d_py),    vo ? v : 0);
        check({tag, ".line"},  int'(d_ln),    int'(ln));
        check({tag, ".frame"}, int'(d_fr),    int'(fr));
    endtask

    // Expected outputs of the 14x7 active-high instance at position (h,v).
    task automatic exp_s(input string tag, input int h, input int v,
                         input bit run, input bit ln, input bit fr);
        bit vo;
        vo = run && (h < 8) && (v < 4);
        check({tag, ".hcnt"},  int'(s_hcnt),  h);
        check({tag, ".vcnt"},  int'(s_vcnt),  v);
        check({tag, ".hsync"}, int'(s_hsync), (h >= 10 && h <= 11) ? 1 : 0);
        check({tag, ".vsync"}, int'(s_vsync), (v == 5) ? 1 : 0);
        check({tag, ".von"},   int'(s_vo),    int'(vo));
        check({tag, ".px"},    int'(s_px),    vo ? h : 0);
        check({tag, ".py"},    int'(s_py),    vo ? v : 0);
        check({tag, ".line"},  int'(s_ln),    int'(ln));
        check({tag, ".frame"}, int'(s_fr),    int'(fr));
    endtask

    task automatic tick_d(input bit en);
        @(negedge clk);
        en_d = en;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_s(input bit en);
        @(negedge clk);
        en_s = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low;
        int n_ln;
        int n_fr;
        int h;
        int v;

        rst_d = 1'b1; en_d = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        rst_s = 1'b0;
        #1;
        exp_d("rst_d", 0, 0, 0, 0, 0);
        exp_s("rst_s", 0, 0, 0, 0, 0);

        tick_d(1'b0);
        exp_d("idle_d", 0, 0, 0, 0, 0);

        // One full line at one pixel per clk.
        hs_low = 0;
        for (int t = 1; t <= 800; t++) begin
            tick_d(1'b1);
            exp_d($sformatf("ln%0d", t), t % 800, t / 800, 1, (t % 800) == 0, 0);
            if (d_hsync == 1'b0) hs_low++;
        end
        check("hs_width", hs_low, 96);

        tick_d(1'b0);
        exp_d("gap_d", 0, 1, 1, 0, 0);
        tick_d(1'b1);
        exp_d("resume_d", 1, 1, 1, 0, 0);
        tick_d(1'b0);

        // Small timing, pix_en every 4th clk, one frame plus one tick.
        n_ln = 0;
        n_fr = 0;
        h = 0;
        v = 0;
        for (int t = 1; t <= 99; t++) begin
            repeat (3) begin
                tick_s(1'b0);
                exp_s($sformatf("hold%0d", t), h, v, t > 1, 0, 0);
                n_ln += int'(s_ln);
                n_fr += int'(s_fr);
            end
            h = t % 14;
            v = (t / 14) % 7;
            tick_s(1'b1);
            exp_s($sformatf("tk%0d", t), h, v, 1, h == 0, (h == 0) && (v == 0));
            n_ln += int'(s_ln);
            n_fr += int'(s_fr);
        end
        check("n_line", n_ln, 7);
        check("n_frame", n_fr, 1);

        // Continue at full rate into the vsync line, then reset mid-pulse.
        for (int t = 100; t <= 180; t++) begin
            h = t % 14;
            v = (t / 14) % 7;
            tick_s(1'b1);
            exp_s($sformatf("run%0d", t), h, v, 1, h == 0, (h == 0) && (v == 0));
        end
        @(negedge clk);
        en_s  = 1'b0;
        rst_s = 1'b1;
        #1;
        exp_s("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_s = 1'b0;
        #1;
        exp_s("rel", 0, 0, 0, 0, 0);
        tick_s(1'b1);
        exp_s("post", 1, 0, 1, 0, 0);
        tick_s(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the horizontal and vertical pixel counters for the VGA output path.
- Generates hsync, vsync, video_on, the pixel coordinates and the line/frame strobes that the pixel source and frame logic consume.
- Runs on the system clock and advances only on a pixel-rate enable tick.
- Default timing is 640x480@60 (800 x 525 totals).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)
- CW, 16, counter and coordinate width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel tick; counters advance only when this is 1
- hcnt  out  CW  horizontal count, 0..H_TOTAL-1
- vcnt  out  CW  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, at level SYNC_POL while asserted
- vsync  out  1  vertical sync, at level SYNC_POL while asserted
- video_on  out  1  high while both the horizontal and vertical phases are ACTIVE
- px  out  CW  equals hcnt when video_on=1, else 0
- py  out  CW  equals vcnt when video_on=1, else 0
- line_start  out  1  one-clk pulse when hcnt wraps to 0
- frame_start  out  1  one-clk pulse when (hcnt,vcnt) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL is the vertical equivalent (525). Both totals must fit in CW bits.
- Reset (async):
  - hcnt=0, vcnt=0, px=0, py=0.
  - Both phase FSMs in ACTIVE; running=0.
  - video_on=0, line_start=0, frame_start=0.
  - hsync=vsync=~SYNC_POL (deasserted).
- Horizontal phase FSM. States and hcnt ranges: ACTIVE [0,639] -> FRONT [640,655] -> SYNC [656,751] -> BACK [752,799] -> ACTIVE.
  - Transitions happen on a pix_en cycle in which hcnt leaves the last count of the current phase.
- Vertical phase FSM. States and vcnt ranges: ACTIVE [0,479] -> FRONT [480,489] -> SYNC [490,491] -> BACK [492,524] -> ACTIVE.
  - Advances only on a pix_en cycle in which hcnt wraps.
- Counter update on a pix_en=1 cycle:
  - hcnt = (hcnt==H_TOTAL-1) ? 0 : hcnt+1.
  - On that hcnt wrap, vcnt = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
- pix_en=0: every output holds its value, except the strobes, which drop to 0.
- Alignment:
  - hsync, vsync, video_on, px, py are registered and decoded from the next counter values.
  - They therefore always describe the hcnt/vcnt currently on the outputs.
  - Decode latency relative to the counters is 0; relative to pix_en it is 1 clk.
- running flag:
  - Set on the first pix_en after reset.
  - video_on is forced to 0 while running=0.
  - The first pix_en after reset moves hcnt from 0 to 1 and pulses neither line_start nor frame_start.
- Strobes: line_start=1 for exactly one clk on the cycle after hcnt is updated to 0. frame_start=1 on that same cycle only if vcnt also became 0.
- Sync levels:
  - hsync=SYNC_POL exactly while the horizontal FSM is in SYNC, else ~SYNC_POL.
  - vsync=SYNC_POL exactly while the vertical FSM is in SYNC, for whole lines from hcnt 0 through H_TOTAL-1, else ~SYNC_POL.
- Simultaneous events: an hcnt wrap on the last line produces the vertical wrap and the frame_start in the same update; nothing is lost.
- Reset mid-frame: immediate return to the reset values. No partial sync pulse is stretched.
- pix_en held high permanently: legal; one pixel per clk.

Decomposition:
- Shared package vga_timing_pkg:
  - Phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
  - Default 640x480@60 timing constants.
  - Total/boundary helper functions (ACTIVE_END, SYNC_START, etc.).
- Sub-module vga_phase_counter, instantiated twice (horizontal, vertical):
  - Ports: clk, rst, step, four phase-length parameters.
  - Outputs: count, phase, wrap.
  - The vertical instance's step = horizontal wrap AND pix_en.
- The top level handles the decode registers, the running flag, and px/py and the strobes.

Test Plan:
- Reset release, then pix_en every clk: hcnt goes 0,1,2,...; first line_start when hcnt returns to 0 after 800 ticks; vcnt=1 at that point.
- hsync check: hsync=0 for exactly 96 ticks, hcnt 656..751; video_on=1 for hcnt 0..639 on line 0, 0 at hcnt 640.
- Full frame: after 800*525=420000 ticks, frame_start pulses once with hcnt=0, vcnt=0; vsync=0 for 1600 ticks, vcnt 490..491.
- pix_en every 4th clk: 420000 ticks take 1680000 clks; line_start and frame_start stay 1-clk wide; all other outputs hold between ticks.
- Assert rst at hcnt=700, vcnt=491 (in vsync): next cycle vsync=1, hsync=1, hcnt=0, vcnt=0, video_on=0; after the first pix_en, video_on=1 and hcnt=1.
- SYNC_POL=1 and a small timing (H 8/2/2/2, V 4/1/1/1): hsync high exactly at hcnt 10..11; vsync high exactly on vcnt 5; px/py are 0 outside the active region.
